// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for execute and load writebacks, with a
// per-register busy scoreboard that stalls decode on outstanding loads.
`timescale 1ns/1ps
module wb_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exe_valid_i,
  input  logic [4:0]            exe_rd_i,
  input  logic [DATA_WIDTH-1:0] exe_data_i,
  output logic                  exe_ready_o,
  input  logic                  mem_valid_i,
  input  logic [4:0]            mem_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_ready_o,
  input  logic                  issue_valid_i,
  input  logic                  issue_is_load_i,
  input  logic [4:0]            issue_rs1_i,
  input  logic [4:0]            issue_rs2_i,
  input  logic [4:0]            issue_rd_i,
  output logic                  stall_o,
  output logic                  wr_en_o,
  output logic [4:0]            rd_addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [31:0]           busy_o
);
  typedef struct packed {
    logic                  vld;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] clr_vec, set_vec, busy_eff;
  logic        exe_nz, mem_nz, exe_win, mem_win, issue_go;
  wb_req_t     win;

  always_comb begin
    exe_nz  = exe_valid_i && (exe_rd_i != 5'd0);
    mem_nz  = mem_valid_i && (mem_rd_i != 5'd0);
    // exe is only forced ahead of mem once it has been starved MAX_WAIT cycles
    exe_win = rst_n && exe_nz && (!mem_nz || (wait_cnt_q == 4'(MAX_WAIT)));
    mem_win = rst_n && mem_nz && !exe_win;

    exe_ready_o = rst_n && exe_valid_i && ((exe_rd_i == 5'd0) || exe_win);
    mem_ready_o = rst_n && mem_valid_i && ((mem_rd_i == 5'd0) || mem_win);

    win = '0;
    if (exe_win)      win = '{vld: 1'b1, rd: exe_rd_i, data: exe_data_i};
    else if (mem_win) win = '{vld: 1'b1, rd: mem_rd_i, data: mem_data_i};
    wr_en_o   = win.vld;
    rd_addr_o = win.rd;
    data_o    = win.data;

    wait_cnt_d = wait_cnt_q;
    if (!exe_valid_i || exe_ready_o)
      wait_cnt_d = 4'd0;
    else if (exe_nz && (wait_cnt_q != 4'(MAX_WAIT)))
      wait_cnt_d = wait_cnt_q + 4'd1;

    // a register whose load lands this cycle is forwarded, so it does not stall
    clr_vec  = mem_win ? (32'd1 << mem_rd_i) : 32'd0;
    busy_eff = busy_q & ~clr_vec;
    stall_o  = rst_n && issue_valid_i &&
               (((issue_rs1_i != 5'd0) && busy_eff[issue_rs1_i]) ||
                ((issue_rs2_i != 5'd0) && busy_eff[issue_rs2_i]) ||
                ((issue_rd_i  != 5'd0) && busy_eff[issue_rd_i]));

    issue_go = rst_n && issue_valid_i && !stall_o && issue_is_load_i &&
               (issue_rd_i != 5'd0);
    set_vec  = issue_go ? (32'd1 << issue_rd_i) : 32'd0;
    // set after clear: a new load to the same register owns it
    busy_d   = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
      busy_q     <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_o = {busy_q[31:1], 1'b0};
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; register-file writes are checked
// against a queue of expected {rd, data} pushed when stimulus is driven.
`timescale 1ns/1ps
module tb_wb_port_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          exe_valid, mem_valid, issue_valid, issue_is_load;
  logic [4:0]    exe_rd, mem_rd, rs1, rs2, ird;
  logic [DW-1:0] exe_data, mem_data;
  logic          exe_ready, mem_ready, stall, wr_en;
  logic [4:0]    rd_addr;
  logic [DW-1:0] data;
  logic [31:0]   busy;

  int checks = 0;
  int errors = 0;
  logic [DW+4:0] exp_q[$];

  wb_port_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .exe_valid_i(exe_valid), .exe_rd_i(exe_rd), .exe_data_i(exe_data), .exe_ready_o(exe_ready),
    .mem_valid_i(mem_valid), .mem_rd_i(mem_rd), .mem_data_i(mem_data), .mem_ready_o(mem_ready),
    .issue_valid_i(issue_valid), .issue_is_load_i(issue_is_load),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_rd_i(ird),
    .stall_o(stall), .wr_en_o(wr_en), .rd_addr_o(rd_addr), .data_o(data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // write monitor: every register-file write must match the oldest expectation
  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", rd_addr, data);
      end else begin
        logic [DW+4:0] e;
        e = exp_q.pop_front();
        if ({rd_addr, data} !== e) begin
          errors++;
          $display("FAIL wb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rd_addr, data, e[DW+4:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic idle();
    exe_valid = 0; exe_rd = 0; exe_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_is_load = 0; rs1 = 0; rs2 = 0; ird = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    exe_valid = 1; exe_rd = 3; exe_data = 32'h1111_1111;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h2222_2222;
    issue_valid = 1; issue_is_load = 1; ird = 6;
    @(negedge clk);
    checks++;
    if ({wr_en, exe_ready, mem_ready, stall} !== 4'b0 || busy !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b er=%b mr=%b st=%b busy=%h, required all 0",
               wr_en, exe_ready, mem_ready, stall, busy);
    end
    step();
    idle();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (busy !== 32'd0) begin
      errors++;
      $display("FAIL reset_busy: got %h, required 0", busy);
    end
  endtask

  task automatic test_exe_only();
    step();
    idle();
    exe_valid = 1; exe_rd = 5; exe_data = 32'hDEAD_BEEF;
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    @(negedge clk);
    checks++;
    if ({exe_ready, mem_ready, wr_en} !== 3'b101 || rd_addr !== 5'd5 || data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL exe_only: got er=%b mr=%b wr=%b rd=%0d data=%h, required 1 0 1 5 deadbeef",
               exe_ready, mem_ready, wr_en, rd_addr, data);
    end
    step();
    idle();
  endtask

  task automatic test_arbitration();
    bit ev_pat[19]  = '{1,1,1,1,1,1,1,1,1,1, 1,1,1,0, 1,1,1,1,1};
    bit exe_pat[19] = '{0,0,0,0,1,0,0,0,0,1, 0,0,0,0, 0,0,0,0,1};
    int ecnt = 0;
    for (int i = 0; i < 19; i++) begin
      idle();
      exe_valid = ev_pat[i]; exe_rd = 5'd3; exe_data = 32'hE000_0000 + ecnt;
      mem_valid = 1;         mem_rd = 5'd4; mem_data = 32'hA000_0000 + i;
      if (exe_pat[i]) exp_q.push_back({5'd3, exe_data});
      else            exp_q.push_back({5'd4, mem_data});
      @(negedge clk);
      checks++;
      if (exe_ready !== (exe_pat[i] ? 1'b1 : 1'b0) || mem_ready !== (exe_pat[i] ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL arb_cycle%0d: got er=%b mr=%b, required er=%b mr=%b",
                 i, exe_ready, mem_ready, exe_pat[i], !exe_pat[i]);
      end
      if (exe_pat[i]) ecnt++;
      step();
    end
    idle();
  endtask

  task automatic test_x0();
    logic [3:0] exp_rdy_wr[3] = '{4'b1111, 4'b1111, 4'b1100};
    logic [4:0] erd[3] = '{5'd0, 5'd6, 5'd0};
    logic [4:0] mrd[3] = '{5'd7, 5'd0, 5'd0};
    for (int i = 0; i < 3; i++) begin
      idle();
      exe_valid = 1; exe_rd = erd[i]; exe_data = 32'hC0DE_0000 + i;
      mem_valid = 1; mem_rd = mrd[i]; mem_data = 32'hBEEF_0000 + i;
      if (mrd[i] != 0)      exp_q.push_back({mrd[i], mem_data});
      else if (erd[i] != 0) exp_q.push_back({erd[i], exe_data});
      @(negedge clk);
      checks++;
      if ({exe_ready, mem_ready, wr_en, (rd_addr != 0)} !== exp_rdy_wr[i]) begin
        errors++;
        $display("FAIL x0_case%0d: got er=%b mr=%b wr=%b rd=%0d, required flags %b",
                 i, exe_ready, mem_ready, wr_en, rd_addr, exp_rdy_wr[i]);
      end
      step();
    end
    idle();
  endtask

  task automatic test_hazard();
    issue_valid = 1; issue_is_load = 1; ird = 9;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL haz_load_issue: got stall=%b, required 0", stall);
    end
    step();
    @(negedge clk);
    checks++;
    if (busy !== 32'h0000_0200) begin
      errors++; $display("FAIL haz_busy_set: got %h, required 00000200", busy);
    end
    // dependants via rs2, rs1, rd; the last is a load that must not set busy[10]
    for (int i = 0; i < 3; i++) begin
      idle();
      issue_valid = 1;
      if (i == 0) begin rs2 = 9; ird = 1; end
      if (i == 1) begin rs1 = 9; ird = 2; end
      if (i == 2) begin rs1 = 9; ird = 10; issue_is_load = 1; end
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin
        errors++; $display("FAIL haz_stall%0d: got stall=%b, required 1", i, stall);
      end
      step();
    end
    checks++;
    if (busy !== 32'h0000_0200) begin
      errors++; $display("FAIL haz_stalled_load: got %h, required 00000200", busy);
    end
    idle();
    issue_valid = 1; rs2 = 9; ird = 1;
    mem_valid = 1; mem_rd = 9; mem_data = 32'h0000_0909;
    exp_q.push_back({5'd9, 32'h0000_0909});
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL haz_forward: got stall=%b mr=%b, required 0 1", stall, mem_ready);
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (busy !== 32'd0) begin
      errors++; $display("FAIL haz_busy_clear: got %h, required 0", busy);
    end
  endtask

  task automatic test_set_wins();
    issue_valid = 1; issue_is_load = 1; ird = 9;
    step();
    idle();
    mem_valid = 1; mem_rd = 9; mem_data = 32'h5E7_0009;
    issue_valid = 1; issue_is_load = 1; ird = 9;
    exp_q.push_back({5'd9, 32'h5E7_0009});
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL setwin_cycle: got stall=%b mr=%b, required 0 1", stall, mem_ready);
    end
    step();
    idle();
    issue_valid = 1; rs1 = 9; ird = 2;
    @(negedge clk);
    checks++;
    if (busy !== 32'h0000_0200 || stall !== 1'b1) begin
      errors++; $display("FAIL setwin_busy: got busy=%h stall=%b, required 00000200 1", busy, stall);
    end
  endtask

  task automatic test_reset_mid();
    step();
    idle();
    exe_valid = 1; exe_rd = 3; exe_data = 32'h3333_3333;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h4444_4444;
    issue_valid = 1; rs1 = 9;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({wr_en, exe_ready, mem_ready, stall} !== 4'b0 || busy !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid: got wr=%b er=%b mr=%b st=%b busy=%h, required all 0",
               wr_en, exe_ready, mem_ready, stall, busy);
    end
    step();
    rst_n = 1;
    exp_q.push_back({5'd4, 32'h4444_4444});
    @(negedge clk);
    checks++;
    if (busy !== 32'd0 || mem_ready !== 1'b1 || exe_ready !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: got busy=%h mr=%b er=%b st=%b, required 0 1 0 0",
               busy, mem_ready, exe_ready, stall);
    end
    step();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_exe_only();
    test_arbitration();
    test_x0();
    test_hazard();
    test_set_wins();
    test_reset_mid();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_missing: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between two writeback requesters (execute results and load returns) and keeps a per-register busy scoreboard for outstanding loads. Sits between the execute/memory stages and the register file, and drives the file's write enable, destination address and write data. It also supplies the decode stage with a hazard stall, so no instruction issues while it reads or overwrites a register whose load is still in flight.

## Interface
- DATA_WIDTH, 32, width of writeback data.
- MAX_WAIT, 4, consecutive cycles the execute requester may be denied before it is forced to win; range 1..15.
- clk  input  1  core clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- exe_valid_i  input  1  execute result ready to write.
- exe_rd_i  input  5  execute destination register.
- exe_data_i  input  DATA_WIDTH  execute result.
- exe_ready_o  output  1  execute result accepted this cycle.
- mem_valid_i  input  1  load data ready to write.
- mem_rd_i  input  5  load destination register.
- mem_data_i  input  DATA_WIDTH  load data.
- mem_ready_o  output  1  load data accepted this cycle.
- issue_valid_i  input  1  decode presents an instruction.
- issue_is_load_i  input  1  presented instruction is a load.
- issue_rs1_i, issue_rs2_i, issue_rd_i  input  5 each  register fields of the presented instruction.
- stall_o  output  1  decode must hold; the instruction does not issue.
- wr_en_o  output  1  register file write enable.
- rd_addr_o  output  5  register file write address.
- data_o  output  DATA_WIDTH  register file write data.
- busy_o  output  32  scoreboard vector; bit 0 is always 0.

## Operation
- Handshake: a transfer occurs when valid and ready are both high at a rising edge. Requesters hold rd and data stable while valid is high and ready is low.
- x0 requests (rd == 0) are accepted in the cycle they are valid, regardless of arbitration. They never assert wr_en_o and never consume the port.
- Arbitration for non-x0 requests:
  - Only one valid: that requester wins.
  - Both valid: mem wins, unless wait_cnt == MAX_WAIT, in which case exe wins.
- Write port: wr_en_o = 1 with the winner's rd and data. Otherwise wr_en_o = 0, and rd_addr_o/data_o are 0.
- wait_cnt (saturating at MAX_WAIT):
  - increments when exe_valid_i is high, exe_rd_i != 0 and exe loses;
  - clears to 0 when exe is accepted or exe_valid_i is low.
- Scoreboard:
  - busy[r] is set when an issue is accepted (issue_valid_i && !stall_o) with issue_is_load_i && issue_rd_i == r && r != 0.
  - busy[r] is cleared when mem is accepted with mem_rd_i == r.
  - Set and clear to the same r in one cycle: set wins, because the new load owns the register.
- Hazard:
  - stall_o = issue_valid_i && (busy[rs1] || busy[rs2] || busy[rd]) for nonzero fields.
  - A busy bit being cleared in the current cycle does not stall, because the register file forwards the write data combinationally.
- Reset: busy = 0, wait_cnt = 0. While rst_n is low, wr_en_o, exe_ready_o, mem_ready_o and stall_o are all 0.

## Timing
- Grant, readies, write port and stall are combinational from the current-cycle inputs and registered state. Zero-cycle latency from valid to write.
- The register file captures the write at the same rising edge as the accepting handshake.
- busy_o and wait_cnt update on the rising edge. A newly set busy bit stalls dependants starting the next cycle.
- Worst-case exe wait with mem continuously valid: MAX_WAIT denied cycles, then acceptance on cycle MAX_WAIT+1.
- Reset asserted mid-transfer:
  - all in-flight state is dropped immediately, asynchronously;
  - no write occurs at the edges while rst_n is low;
  - requesters re-present after reset.
- Deassertion of rst_n is synchronised externally. The first active edge behaves as a normal cycle.

## Test plan
- Exe only, rd=5, data=0xDEADBEEF → same cycle: exe_ready_o=1, wr_en_o=1, rd_addr_o=5, data_o=0xDEADBEEF.
- Both valid every cycle, non-x0, MAX_WAIT=4 → mem accepted 4 cycles in a row, exe accepted on cycle 5, wait_cnt back to 0, then mem wins again.
- Exe rd=0 and mem rd=7 valid together → both readies 1, wr_en_o=1, rd_addr_o=7, no write to x0.
- Load issued with rd=9, then an instruction with rs2=9 → stall_o=1 until the mem writeback to rd=9 is accepted. stall_o=0 in that acceptance cycle; busy_o[9]=0 after the edge.
- Same cycle: mem writeback to rd=9 accepted and a new load to rd=9 issued → busy_o[9] stays 1 and the next dependant stalls.
- rst_n pulsed low while both requesters are valid and busy_o=0x00000200 → outputs 0 immediately, busy_o=0 after release, no register file write during reset.
